// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu_muldiv block: opcode constants, the
// controller state encoding and helpers derived from the datapath width.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Opcodes presented on ALU_Operation_i
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_LUI   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_BNE   = 4'b1001;
  localparam logic [3:0] OP_BLT   = 4'b1010;
  localparam logic [3:0] OP_BGE   = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_MULHU = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  // LUI places the immediate above the low 12 bits
  localparam int LUI_SHAMT = 12;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Number of shift-amount bits taken from B_i for a given datapath width
  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

  // MUL, MULHU, DIVU and REMU all live in the 11xx opcode quadrant
  function automatic logic is_iter_op(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

  // Within the iterative quadrant, bit 1 selects divide over multiply
  function automatic logic is_div_op(input logic [3:0] op);
    return is_iter_op(op) & op[1];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// Iterative unsigned multiplier / restoring divider, one step per clock,
// WIDTH steps per operation.
//   clk, reset   : clock and asynchronous active-low reset
//   start        : load operands and begin (only asserted while idle)
//   op[1:0]      : 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a, b         : operands, captured on start
//   done         : high during the final step; result is valid then
//   result       : value produced by the final step (combinational)
// ---------------------------------------------------------------------------
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = shamt_width(WIDTH);

  logic             active_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] opnd_r;   // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] hi_r;     // product high half / partial remainder
  logic [WIDTH-1:0] lo_r;     // multiplier bits / dividend-quotient bits

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic [WIDTH-1:0] hi_next_s;
  logic [WIDTH-1:0] lo_next_s;

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit is set; the carry becomes the new MSB after the shift.
  assign mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});

  // Restoring divide: bring in the next dividend bit, try subtracting the
  // divisor, and keep the difference only if it did not go negative.
  assign div_shift_s = {hi_r, lo_r[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_r};

  // Next-step values for both halves of the working register
  always_comb begin
    hi_next_s = hi_r;
    lo_next_s = lo_r;
    if (op_r[1]) begin
      hi_next_s = div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
      lo_next_s = {lo_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
    end else begin
      hi_next_s = mul_sum_s[WIDTH:1];
      lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  assign done   = active_r && (cnt_r == CNT_W'(WIDTH - 1));
  // Odd ops (MULHU, REMU) want the high half, even ops the low half
  assign result = op_r[0] ? hi_next_s : lo_next_s;

  // Operand capture on start, then one iteration per clock until done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_r <= 1'b0;
      cnt_r    <= '0;
      op_r     <= 2'b00;
      opnd_r   <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= '0;
      op_r     <= op;
      hi_r     <= '0;
      if (op[1]) begin
        opnd_r <= b;
        lo_r   <= a;
      end else begin
        opnd_r <= a;
        lo_r   <= b;
      end
    end else if (active_r) begin
      hi_r  <= hi_next_s;
      lo_r  <= lo_next_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (done) begin
        active_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// ---------------------------------------------------------------------------
// alu_muldiv
// Integer ALU with single-cycle arithmetic/logic/compare ops and an
// iterative unsigned multiply/divide unit.
//   clk, reset        : clock, asynchronous active-low reset
//   Valid_i / Ready_o : request handshake, accepted when both high at a
//                       rising edge; Ready_o is high only while IDLE
//   ALU_Operation_i   : 4-bit opcode (see alu_pkg)
//   A_i, B_i          : operands
//   Valid_o           : one-cycle pulse when ALU_Result_o/Zero_o update
//   ALU_Result_o      : registered result, held between pulses
//   Zero_o            : registered, high when ALU_Result_o is zero
//   Busy_o            : an iterative operation is in flight
// ---------------------------------------------------------------------------
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid_i,
  output logic             Ready_o,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             Valid_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o,
  output logic             Busy_o
);

  localparam int SHAMT_W = shamt_width(WIDTH);

  state_t           state_r;
  logic             valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;

  logic [WIDTH-1:0] alu_s;
  logic             go_iter_s;
  logic             start_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_result_s;

  // A zero divisor is answered directly, so only multiplies and real
  // divides take the iterative path.
  assign go_iter_s = is_iter_op(ALU_Operation_i) &&
                     !(is_div_op(ALU_Operation_i) && (B_i == '0));
  assign start_s   = Valid_i && (state_r == ST_IDLE) && go_iter_s;

  // Single-cycle result, including the divide-by-zero answers
  always_comb begin
    alu_s = '0;
    case (ALU_Operation_i)
      OP_ADD:   alu_s = A_i + B_i;
      OP_SUB:   alu_s = A_i - B_i;
      OP_OR:    alu_s = A_i | B_i;
      OP_SLL:   alu_s = A_i << B_i[SHAMT_W-1:0];
      OP_SRL:   alu_s = A_i >> B_i[SHAMT_W-1:0];
      OP_LUI:   alu_s = B_i << LUI_SHAMT;
      OP_AND:   alu_s = A_i & B_i;
      OP_XOR:   alu_s = A_i ^ B_i;
      OP_BEQ:   alu_s = {{(WIDTH-1){1'b0}}, (A_i == B_i)};
      OP_BNE:   alu_s = {{(WIDTH-1){1'b0}}, (A_i != B_i)};
      OP_BLT:   alu_s = {{(WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
      OP_BGE:   alu_s = {{(WIDTH-1){1'b0}}, ($signed(A_i) >= $signed(B_i))};
      OP_DIVU:  alu_s = '1;
      OP_REMU:  alu_s = A_i;
      default:  alu_s = '0;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .op     (ALU_Operation_i[1:0]),
    .a      (A_i),
    .b      (B_i),
    .done   (iter_done_s),
    .result (iter_result_s)
  );

  // Controller: accepts requests in IDLE, waits out iterative ops in BUSY,
  // and registers every result together with its Valid_o pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      valid_r  <= 1'b0;
      result_r <= '0;
      zero_r   <= 1'b1;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Valid_i) begin
            if (go_iter_s) begin
              state_r <= ST_BUSY;
            end else begin
              result_r <= alu_s;
              zero_r   <= (alu_s == '0);
              valid_r  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (iter_done_s) begin
            state_r  <= ST_IDLE;
            result_r <= iter_result_s;
            zero_r   <= (iter_result_s == '0);
            valid_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign Ready_o      = (state_r == ST_IDLE);
  assign Busy_o       = (state_r == ST_BUSY);
  assign Valid_o      = valid_r;
  assign ALU_Result_o = result_r;
  assign Zero_o       = zero_r;

endmodule
